// File: rtl/mix_columns_iter.sv
// Iterative MixColumns/InvMixColumns with fused AddRoundKey, COLS_PER_CYCLE columns per clock.
// Define MIXCOL_INV_EN to build the inverse datapath; otherwise in_inv is ignored.
module mix_columns_iter #(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_inv,
   input  logic [127:0] in_block,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block,
   output logic         busy
);

   localparam int unsigned Cpc = COLS_PER_CYCLE;

   generate
      if (!(Cpc == 1 || Cpc == 2 || Cpc == 4)) begin : g_bad_cpc
         $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e         r_state, w_state_next;
   logic [127:0]   r_work, r_key, w_work_next;
   logic [2:0]     r_cnt;
   logic           w_last;
   logic [1:0]     w_col_idx [Cpc];
   logic [6:0]     w_hi      [Cpc];
   logic [31:0]    w_col_in  [Cpc];
   logic [31:0]    w_key_col [Cpc];
   logic [31:0]    w_col_out [Cpc];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_fwd(input logic [31:0] col);
      logic [7:0]  a [4];
      logic [7:0]  x [4];
      logic [31:0] res;
      logic [1:0]  j1, j2, j3;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         a[i] = col[31-8*i -: 8];
         x[i] = xt(a[i]);
      end
      for (int r = 0; r < 4; r++) begin
         j1 = 2'(r + 1);
         j2 = 2'(r + 2);
         j3 = 2'(r + 3);
         res[31-8*r -: 8] = x[r] ^ x[j1] ^ a[j1] ^ a[j2] ^ a[j3];
      end
      return res;
   endfunction

`ifdef MIXCOL_INV_EN
   logic r_inv;

   function automatic logic [31:0] mix_inv(input logic [31:0] col);
      logic [7:0]  a, x2, x4, x8;
      logic [7:0]  m9 [4];
      logic [7:0]  mb [4];
      logic [7:0]  md [4];
      logic [7:0]  me [4];
      logic [31:0] res;
      logic [1:0]  j1, j2, j3;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         a  = col[31-8*i -: 8];
         x2 = xt(a);
         x4 = xt(x2);
         x8 = xt(x4);
         m9[i] = x8 ^ a;
         mb[i] = x8 ^ x2 ^ a;
         md[i] = x8 ^ x4 ^ a;
         me[i] = x8 ^ x4 ^ x2;
      end
      for (int r = 0; r < 4; r++) begin
         j1 = 2'(r + 1);
         j2 = 2'(r + 2);
         j3 = 2'(r + 3);
         res[31-8*r -: 8] = me[r] ^ mb[j1] ^ md[j2] ^ m9[j3];
      end
      return res;
   endfunction
`else
   logic w_unused_inv;
   assign w_unused_inv = in_inv;
`endif

   // Column c occupies bits {~c, 5'h1f} down to 32 bits below.
   for (genvar g = 0; g < Cpc; g++) begin : g_col
      assign w_col_idx[g] = r_cnt[1:0] + 2'(g);
      assign w_hi[g]      = {~w_col_idx[g], 5'h1f};
      assign w_col_in[g]  = r_work[w_hi[g] -: 32];
      assign w_key_col[g] = r_key[w_hi[g] -: 32];
`ifdef MIXCOL_INV_EN
      assign w_col_out[g] = r_inv ? mix_inv(w_col_in[g])
                                  : (mix_fwd(w_col_in[g]) ^ w_key_col[g]);
`else
      assign w_col_out[g] = mix_fwd(w_col_in[g]) ^ w_key_col[g];
`endif
   end

   always_comb begin
      w_work_next = r_work;
      for (int g = 0; g < Cpc; g++) begin
         w_work_next[w_hi[g] -: 32] = w_col_out[g];
      end
   end

   assign w_last = (r_cnt + 3'(Cpc)) == 3'd4;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (in_valid)  w_state_next = StRun;
         StRun:   if (w_last)    w_state_next = StDone;
         StDone:  if (out_ready) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == StIdle);
      out_valid = (r_state == StDone);
      busy      = (r_state != StIdle);
      out_block = r_work;
   end

   // Inverse mode applies the key up front so the column pass is a pure InvMixColumns.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_work <= '0;
         r_key  <= '0;
         r_cnt  <= '0;
`ifdef MIXCOL_INV_EN
         r_inv  <= 1'b0;
`endif
      end else if (r_state == StIdle && in_valid) begin
         r_key <= in_key;
         r_cnt <= '0;
`ifdef MIXCOL_INV_EN
         r_inv  <= in_inv;
         r_work <= in_inv ? (in_block ^ in_key) : in_block;
`else
         r_work <= in_block;
`endif
      end else if (r_state == StRun) begin
         r_work <= w_work_next;
         r_cnt  <= r_cnt + 3'(Cpc);
      end
   end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: one DUT each for COLS_PER_CYCLE = 1, 2, 4, checked
// against table vectors and a GF(2^8) matrix reference model.
module tb_mix_columns_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid  [3];
   logic         out_ready [3];
   logic         in_ready  [3];
   logic         out_valid [3];
   logic         busy      [3];
   logic [127:0] out_block [3];
   logic         in_inv;
   logic [127:0] in_block, in_key;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_inv    (in_inv),
         .in_block  (in_block),
         .in_key    (in_key),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_block (out_block[g]),
         .busy      (busy[g])
      );
   end

   typedef struct {
      logic [127:0] blk;
      logic [127:0] key;
      logic         inv;
      logic [127:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: schoolbook GF(2^8) product and the circulant matrix written out by rows.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] ref_mix(input logic [127:0] blk, input logic [127:0] key,
                                            input logic inv);
      logic [7:0]   coef [4];
      logic [127:0] s, o;
      logic [7:0]   acc;
      logic         eff;
`ifdef MIXCOL_INV_EN
      eff = inv;
`else
      eff = 1'b0;
`endif
      if (eff) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      s = eff ? (blk ^ key) : blk;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) begin
               acc = acc ^ gmul(coef[(k - r + 4) % 4], s[127 - 32*c - 8*k -: 8]);
            end
            o[127 - 32*c - 8*r -: 8] = acc;
         end
      end
      return eff ? o : (o ^ key);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One block through DUT d; lat counts edges from accept until out_valid is seen.
   task automatic run_block(input int d, input logic [127:0] blk, input logic [127:0] key,
                            input logic inv, input logic hold_ready,
                            output logic [127:0] res, output int lat);
      @(negedge clk);
      in_block     = blk;
      in_key       = key;
      in_inv       = inv;
      out_ready[d] = hold_ready;
      in_valid[d]  = 1'b1;
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      in_block    = rnd128();
      in_key      = rnd128();
      in_inv      = $urandom_range(0, 1) == 1;
      lat = 0;
      while (out_valid[d] !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = out_block[d];
      out_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[d] = 1'b0;
      check($sformatf("in_ready_recover d%0d", d), in_ready[d], 1'b1);
      check($sformatf("out_valid_drop d%0d", d), out_valid[d], 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t         vecs [3];
      logic [127:0] res, held, blk, key, exp;
      logic         inv;
      int           lat, n;

      vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h0, 1'b0,
                  128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
      vecs[1] = '{128'hd4d4d4d5_2d26314c_00000000_00000000, {128{1'b1}}, 1'b0,
                  128'h2a2a2829_b2814207_ffffffff_ffffffff};
`ifdef MIXCOL_INV_EN
      vecs[2] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b1,
                  128'hdb135345_f20a225c_01010101_c6c6c6c6};
`else
      // Forward-only build: MixColumns of the input, key 0.
      vecs[2] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b1,
                  ref_mix(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'h0, 1'b0)};
`endif

      rst      = 1'b1;
      in_inv   = 1'b0;
      in_block = '0;
      in_key   = '0;
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset in_ready d%0d", d), in_ready[d], 1'b1);
         check($sformatf("reset out_valid d%0d", d), out_valid[d], 1'b0);
         check($sformatf("reset busy d%0d", d), busy[d], 1'b0);
         check($sformatf("reset out_block d%0d", d), out_block[d], 128'h0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Table vectors on every width.
      for (int d = 0; d < 3; d++) begin
         n = 4 >> d;
         for (int v = 0; v < 3; v++) begin
            run_block(d, vecs[v].blk, vecs[v].key, vecs[v].inv, 1'b0, res, lat);
            check($sformatf("vec%0d data d%0d", v, d), res, vecs[v].exp);
            check($sformatf("vec%0d latency d%0d", v, d), 128'(lat), 128'(n));
         end
      end

      // Random blocks against the model, with out_ready sometimes held high early.
      for (int d = 0; d < 3; d++) begin
         n = 4 >> d;
         for (int i = 0; i < 15; i++) begin
            blk = rnd128();
            key = rnd128();
            inv = $urandom_range(0, 1) == 1;
            run_block(d, blk, key, inv, $urandom_range(0, 1) == 1, res, lat);
            check($sformatf("rand%0d data d%0d", i, d), res, ref_mix(blk, key, inv));
            check($sformatf("rand%0d latency d%0d", i, d), 128'(lat), 128'(n));
         end
      end

      // Backpressure: result must hold and new in_valid pulses must be dropped.
      for (int d = 0; d < 3; d++) begin
         blk = rnd128();
         key = rnd128();
         inv = $urandom_range(0, 1) == 1;
         exp = ref_mix(blk, key, inv);
         @(negedge clk);
         in_block     = blk;
         in_key       = key;
         in_inv       = inv;
         out_ready[d] = 1'b0;
         in_valid[d]  = 1'b1;
         @(posedge clk);
         #1;
         in_valid[d] = 1'b0;
         lat = 0;
         while (out_valid[d] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         held = out_block[d];
         check($sformatf("bp data d%0d", d), held, exp);
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_block    = rnd128();
            in_key      = rnd128();
            in_inv      = ~inv;
            in_valid[d] = 1'b1;
            @(posedge clk);
            #1;
            in_valid[d] = 1'b0;
            check($sformatf("bp hold%0d d%0d", i, d), out_block[d], held);
            check($sformatf("bp out_valid%0d d%0d", i, d), out_valid[d], 1'b1);
            check($sformatf("bp in_ready%0d d%0d", i, d), in_ready[d], 1'b0);
            check($sformatf("bp busy%0d d%0d", i, d), busy[d], 1'b1);
         end
         @(negedge clk);
         out_ready[d] = 1'b1;
         @(posedge clk);
         #1;
         out_ready[d] = 1'b0;
         check($sformatf("bp release in_ready d%0d", d), in_ready[d], 1'b1);
         check($sformatf("bp release busy d%0d", d), busy[d], 1'b0);
         check($sformatf("bp dropped d%0d", d), out_block[d], exp);
      end

      // Reset in the second RUN cycle of the single-column engine.
      @(negedge clk);
      in_block    = vecs[1].blk;
      in_key      = vecs[1].key;
      in_inv      = 1'b0;
      in_valid[0] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[0] = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_mid out_valid", out_valid[0], 1'b0);
      check("rst_mid in_ready", in_ready[0], 1'b1);
      check("rst_mid busy", busy[0], 1'b0);
      check("rst_mid out_block", out_block[0], 128'h0);
      run_block(0, vecs[0].blk, vecs[0].key, vecs[0].inv, 1'b0, res, lat);
      check("rst_mid next data", res, vecs[0].exp);
      check("rst_mid next latency", 128'(lat), 128'd4);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
